// File: rtl/sw_pkg.sv
// Shared definitions for pad-input conditioning blocks: FSM encodings,
// a constant clog2 and the default stable time for the 100 MHz board clock.
package sw_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } sw_state_e;

  // 10 ms at 100 MHz
  localparam int STABLE_CYCLES_DEFAULT = 1000000;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single asynchronous pad bit; reused by other
// pad-input blocks. No logic between stages.
module bit_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sw_debounce.sv
// Switch debouncer: synchronises the raw pad and accepts a new level only after
// STABLE_CYCLES identical samples; emits clean level, edge pulses and a toggle.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic sw_clean,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic toggle
);

  localparam int CNT_W = clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s;
  sw_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sw_clean_q;
  logic             rise_q;
  logic             fall_q;
  logic             toggle_q;

  bit_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (sw),
    .q_o  (s)
  );

  // The first differing sample already counts as one, so commit happens on
  // the STABLE_CYCLES-th consecutive differing sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE_LOW;
      cnt_q      <= '0;
      sw_clean_q <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      toggle_q   <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      unique case (state_q)
        IDLE_LOW: begin
          if (s) begin
            state_q <= WAIT_HIGH;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!s) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q    <= IDLE_HIGH;
            sw_clean_q <= 1'b1;
            rise_q     <= 1'b1;
            toggle_q   <= ~toggle_q;
            cnt_q      <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!s) begin
            state_q <= WAIT_LOW;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q <= '0;
          end
        end
        WAIT_LOW: begin
          if (s) begin
            state_q <= IDLE_HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q    <= IDLE_LOW;
            sw_clean_q <= 1'b0;
            fall_q     <= 1'b1;
            cnt_q      <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE_LOW;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign sw_clean   = sw_clean_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign toggle     = toggle_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Randomised and directed bench for sw_debounce against a sliding-window model:
// the clean level flips once the last STABLE_CYCLES synchronised samples all differ from it.
module tb_sw_debounce;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;

  logic clk;
  logic rst_n;
  logic sw;
  logic sw_clean;
  logic rise_pulse;
  logic fall_pulse;
  logic toggle;

  int n_cmp;
  int n_bad;

  // reference model state
  logic [SYNC-1:0]   syn_m;
  logic [STABLE-1:0] win_m;
  logic clean_m, tog_m, rise_m, fall_m;

  sw_debounce #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .sw_clean  (sw_clean),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .toggle    (toggle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs present before the edge.
  task automatic model_edge();
    logic s_m;
    if (!rst_n) begin
      syn_m   = '0;
      win_m   = '0;
      clean_m = 1'b0;
      tog_m   = 1'b0;
      rise_m  = 1'b0;
      fall_m  = 1'b0;
    end else begin
      s_m    = syn_m[SYNC-1];
      syn_m  = {syn_m[SYNC-2:0], sw};
      win_m  = {win_m[STABLE-2:0], s_m};
      rise_m = 1'b0;
      fall_m = 1'b0;
      if (win_m == {STABLE{~clean_m}}) begin
        clean_m = ~clean_m;
        if (clean_m) begin
          rise_m = 1'b1;
          tog_m  = ~tog_m;
        end else begin
          fall_m = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("clean", 32'(sw_clean), 32'(clean_m));
    chk("rise", 32'(rise_pulse), 32'(rise_m));
    chk("fall", 32'(fall_pulse), 32'(fall_m));
    chk("toggle", 32'(toggle), 32'(tog_m));
    chk("excl", 32'(rise_pulse & fall_pulse), 32'd0);
    $display("cyc t=%0t rst_n=%0b sw=%0b clean=%0b rise=%0b fall=%0b tog=%0b",
             $time, rst_n, sw, sw_clean, rise_pulse, fall_pulse, toggle);
  endtask

  initial begin
    int rc, fc, len;
    n_cmp = 0;
    n_bad = 0;
    syn_m = '0; win_m = '0;
    clean_m = 1'b0; tog_m = 1'b0; rise_m = 1'b0; fall_m = 1'b0;
    rst_n = 1'b0;
    sw    = 1'b0;
    #2;
    step();
    step();
    rst_n = 1'b1;

    // 1: idle low after reset
    repeat (10) step();
    chk("t1_clean", 32'(sw_clean), 32'd0);
    chk("t1_toggle", 32'(toggle), 32'd0);

    // 3: three-cycle bounce is rejected
    sw = 1'b1;
    repeat (3) step();
    sw = 1'b0;
    repeat (8) step();
    chk("t3_clean", 32'(sw_clean), 32'd0);
    chk("t3_toggle", 32'(toggle), 32'd0);

    // 2: held press commits on edge 6
    sw = 1'b1;
    repeat (5) step();
    chk("t2_pre", 32'(sw_clean), 32'd0);
    step();
    chk("t2_clean", 32'(sw_clean), 32'd1);
    chk("t2_rise", 32'(rise_pulse), 32'd1);
    chk("t2_toggle", 32'(toggle), 32'd1);
    step();
    chk("t2_rise_off", 32'(rise_pulse), 32'd0);
    repeat (4) step();

    // 4: held release commits on edge 6, toggle stays
    sw = 1'b0;
    repeat (5) step();
    chk("t4_pre", 32'(sw_clean), 32'd1);
    step();
    chk("t4_clean", 32'(sw_clean), 32'd0);
    chk("t4_fall", 32'(fall_pulse), 32'd1);
    chk("t4_toggle", 32'(toggle), 32'd1);
    repeat (4) step();

    // 5: second press/release returns toggle to 0 with one pulse each
    rc = 0;
    fc = 0;
    sw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      rc += int'(rise_pulse);
      fc += int'(fall_pulse);
    end
    sw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      rc += int'(rise_pulse);
      fc += int'(fall_pulse);
    end
    chk("t5_rises", 32'(rc), 32'd1);
    chk("t5_falls", 32'(fc), 32'd1);
    chk("t5_toggle", 32'(toggle), 32'd0);

    // 6: reset mid-qualification, then a full-latency press from reset
    sw = 1'b1;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    chk("t6_rst_clean", 32'(sw_clean), 32'd0);
    chk("t6_rst_rise", 32'(rise_pulse), 32'd0);
    rst_n = 1'b1;
    repeat (5) step();
    chk("t6_pre", 32'(sw_clean), 32'd0);
    step();
    chk("t6_clean", 32'(sw_clean), 32'd1);
    chk("t6_rise", 32'(rise_pulse), 32'd1);
    chk("t6_toggle", 32'(toggle), 32'd1);

    // random bounce segments with occasional resets
    for (int seg = 0; seg < 600; seg++) begin
      sw  = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 8));
      if ($urandom_range(0, 60) == 0) rst_n = 1'b0;
      for (int i = 0; i < len; i++) begin
        step();
        rst_n = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
